// File: rtl/cpucfg_arbiter.sv
// cpucfg_arbiter: two-slot CPUCFG arbiter feeding an IDLE/LOOKUP/RESP pipeline.
// Define CPUCFG_CACHE_INFO_EN to expose the cache-info words at indices 0x10-0x14.
module cpucfg_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_index,
    input  logic [4:0]  req0_rd,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_index,
    input  logic [4:0]  req1_rd,
    output logic        req1_ready,
    input  logic        flush,
    output logic        resp_valid,
    output logic        resp_port,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    input  logic        resp_ready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    logic        w_grant;
    logic        w_accept;
    logic [31:0] r_index;
    logic [4:0]  r_rd;
    logic        r_port;
    logic [31:0] r_resp_data;
    logic [4:0]  r_resp_rd;
    logic        r_resp_port;

    // Full 32-bit decode: any index outside the defined entries reads as zero.
    function automatic logic [31:0] lookup_word(input logic [31:0] idx);
        logic [31:0] word;
        case (idx)
            32'h0000_0000: word = 32'h0014_C010;
            32'h0000_0001: word = 32'h0000_02F2;
            32'h0000_0002: word = 32'h0000_000C;
            32'h0000_0003: word = 32'h0000_0000;
`ifdef CPUCFG_CACHE_INFO_EN
            32'h0000_0010: word = 32'h0000_0005;
            32'h0000_0011: word = 32'h0000_0004;
            32'h0000_0012: word = 32'h0008_0003;
            32'h0000_0013: word = 32'h0008_0003;
            32'h0000_0014: word = 32'h0008_0003;
`endif
            default:       word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    // Round-robin grant on a tie, otherwise the lone valid slot wins.
    always_comb begin
        w_grant  = 1'b0;
        w_accept = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end else begin
            w_grant = 1'b0;
        end
        w_accept   = (r_state == ST_IDLE) && !flush && (req0_valid || req1_valid);
        req0_ready = w_accept && req0_valid && (w_grant == 1'b0);
        req1_ready = w_accept && req1_valid && (w_grant == 1'b1);
    end

    // Next-state logic; flush overrides every state, including a RESP handshake.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_LOOKUP;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_LOOKUP: w_state_nxt = ST_RESP;
                ST_RESP: begin
                    if (resp_ready) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, grant history, captured request and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_index      <= 32'h0000_0000;
            r_rd         <= 5'd0;
            r_port       <= 1'b0;
            r_resp_data  <= 32'h0000_0000;
            r_resp_rd    <= 5'd0;
            r_resp_port  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last_grant <= w_grant;
                r_port       <= w_grant;
                r_index      <= w_grant ? req1_index : req0_index;
                r_rd         <= w_grant ? req1_rd : req0_rd;
            end
            // Response fields only move on the LOOKUP->RESP step so they hold outside RESP.
            if ((r_state == ST_LOOKUP) && !flush) begin
                r_resp_data <= lookup_word(r_index);
                r_resp_rd   <= r_rd;
                r_resp_port <= r_port;
            end
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_port  = r_resp_port;
    assign resp_rd    = r_resp_rd;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_cpucfg_arbiter.sv
// Scoreboard bench for cpucfg_arbiter: stimulus pushes expected responses, a monitor pops them.
// Honours CPUCFG_CACHE_INFO_EN to select the expected cache-info words.
module tb_cpucfg_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_index, req1_index;
    logic [4:0]  req0_rd, req1_rd;
    logic        req0_ready, req1_ready;
    logic        flush;
    logic        resp_valid, resp_port;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_ready;

    int errors = 0;
    int checks = 0;
    logic [37:0] exp_q[$];
    logic        m_last;
    logic [31:0] base_tbl [4];
    logic [31:0] cache_tbl [5];

    cpucfg_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_index(req0_index), .req0_rd(req0_rd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_index(req1_index), .req1_rd(req1_rd), .req1_ready(req1_ready),
        .flush(flush),
        .resp_valid(resp_valid), .resp_port(resp_port), .resp_rd(resp_rd), .resp_data(resp_data),
        .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_word(input logic [31:0] idx);
        logic [31:0] off;
        if (idx < 32'd4) return base_tbl[idx[1:0]];
`ifdef CPUCFG_CACHE_INFO_EN
        if (idx >= 32'h10 && idx <= 32'h14) begin
            off = idx - 32'h10;
            return cache_tbl[off[2:0]];
        end
`endif
        off = 32'h0;
        return off;
    endfunction

    task automatic check1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: whenever a response is shown it must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got resp_valid=1 expected no response at %0t", $time);
            end else begin
                check1("resp_port", resp_port, exp_q[0][37]);
                check32("resp_rd", {27'd0, resp_rd}, {27'd0, exp_q[0][36:32]});
                check32("resp_data", resp_data, exp_q[0][31:0]);
                if (resp_ready && !flush && !rst) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        m_last = 1'b1;
    endtask

    // Drive a request pair just after a rising edge and check the acceptance cycle.
    task automatic present(input logic v0, input logic [31:0] i0, input logic [4:0] d0,
                           input logic v1, input logic [31:0] i1, input logic [4:0] d1,
                           output logic g);
        req0_valid = v0; req0_index = i0; req0_rd = d0;
        req1_valid = v1; req1_index = i1; req1_rd = d1;
        @(negedge clk);
        g = (v0 && v1) ? ~m_last : v1;
        check1("req0_ready", req0_ready, v0 && !g);
        check1("req1_ready", req1_ready, v1 && g);
        exp_q.push_back(g ? {1'b1, d1, ref_word(i1)} : {1'b0, d0, ref_word(i0)});
        m_last = g;
    endtask

    // Walk LOOKUP and RESP, stalling resp_ready for 'hold' cycles, with requests still raised.
    task automatic complete(input int hold);
        @(posedge clk); #1;
        @(negedge clk);
        check1("lat_cycle1_valid", resp_valid, 1'b0);
        check1("busy_ready0", req0_ready, 1'b0);
        check1("busy_ready1", req1_ready, 1'b0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check1("resp_hold_valid", resp_valid, 1'b1);
            check1("resp_hold_ready0", req0_ready, 1'b0);
            check1("resp_hold_ready1", req1_ready, 1'b0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check1("lat_cycle2_valid", resp_valid, 1'b1);
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        logic       g;
        logic [1:0] vp;
        logic [31:0] idx0, idx1;
        int          k;
        logic        alt [3];
        base_tbl[0] = 32'h0014_C010; base_tbl[1] = 32'h0000_02F2;
        base_tbl[2] = 32'h0000_000C; base_tbl[3] = 32'h0000_0000;
        cache_tbl[0] = 32'h0000_0005; cache_tbl[1] = 32'h0000_0004;
        cache_tbl[2] = 32'h0008_0003; cache_tbl[3] = 32'h0008_0003; cache_tbl[4] = 32'h0008_0003;
        alt[0] = 1'b0; alt[1] = 1'b1; alt[2] = 1'b0;
        req0_index = 32'h0; req1_index = 32'h0; req0_rd = 5'd0; req1_rd = 5'd0;

        do_reset();
        @(negedge clk);
        check1("rst_resp_valid", resp_valid, 1'b0);
        check1("rst_resp_port", resp_port, 1'b0);
        check32("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
        check32("rst_resp_data", resp_data, 32'h0);
        check1("rst_ready0", req0_ready, 1'b0);
        check1("rst_ready1", req1_ready, 1'b0);
        @(posedge clk); #1;

        // Basic single request with 2-cycle latency.
        present(1'b1, 32'h1, 5'd5, 1'b0, 32'h0, 5'd0, g);
        complete(0);

        // Three ties after reset alternate 0,1,0.
        do_reset();
        for (int t = 0; t < 3; t++) begin
            present(1'b1, 32'h0, 5'd1, 1'b1, 32'h2, 5'd2, g);
            check1("tie_alternate", req1_ready, alt[t]);
            complete(0);
        end

        // Backpressure: four stalled RESP cycles.
        present(1'b0, 32'h0, 5'd0, 1'b1, 32'h3, 5'd9, g);
        complete(4);

        // Flush while IDLE blocks acceptance.
        flush = 1'b1; req0_valid = 1'b1; req0_index = 32'h1; req0_rd = 5'd4;
        @(negedge clk);
        check1("flush_idle_ready0", req0_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; req0_valid = 1'b0;

        // Flush in LOOKUP drops the response; next cycle takes a new request.
        present(1'b1, 32'h2, 5'd7, 1'b0, 32'h0, 5'd0, g);
        @(posedge clk); #1;
        flush = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        void'(exp_q.pop_back());
        check1("flush_lookup_valid", resp_valid, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        present(1'b0, 32'h0, 5'd0, 1'b1, 32'h0, 5'd3, g);
        check1("post_flush_valid", resp_valid, 1'b0);
        complete(1);

        // Out-of-range and cache-info indices.
        present(1'b1, 32'h8000_0001, 5'd11, 1'b0, 32'h0, 5'd0, g);
        complete(0);
        present(1'b1, 32'h0000_0011, 5'd12, 1'b0, 32'h0, 5'd0, g);
        complete(1);

        // Reset while stalled in RESP abandons the response and restores tie order.
        present(1'b1, 32'h1, 5'd13, 1'b1, 32'h0, 5'd14, g);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resp_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check1("pre_rst_resp_valid", resp_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        exp_q.delete();
        m_last = 1'b1;
        @(negedge clk);
        check1("rst_resp_abandon", resp_valid, 1'b0);
        check32("rst_mid_data", resp_data, 32'h0);
        check1("rst_mid_ready0", req0_ready, 1'b0);
        @(posedge clk); #1;
        present(1'b1, 32'h2, 5'd15, 1'b1, 32'h3, 5'd16, g);
        check1("rst_tie_slot0", req0_ready, 1'b1);
        complete(0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 25; n++) begin
            vp = 2'($urandom_range(1, 3));
            k = $urandom_range(0, 10);
            idx0 = (k < 4) ? 32'(k) : (k < 9) ? 32'h10 + 32'(k - 4) : (k == 9) ? 32'h8000_0001 : $urandom;
            k = $urandom_range(0, 10);
            idx1 = (k < 4) ? 32'(k) : (k < 9) ? 32'h10 + 32'(k - 4) : (k == 9) ? 32'h0001_0002 : $urandom;
            present(vp[0], idx0, 5'($urandom_range(0, 31)), vp[1], idx1, 5'($urandom_range(0, 31)), g);
            complete($urandom_range(0, 2));
        end

        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
